subtractor_serial_nbit: RTL and testbench

//  Bit-serial N-bit subtractor with start/busy/done handshake: difference = a - b - borrow_in.

---
 rtl/subtractor_serial_nbit.sv | 161 ++++++++++++++++
 tb/tb_subtractor_serial_nbit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_serial_nbit.sv
// Bit-serial N-bit subtractor: difference = a - b - borrow_in, one bit per cycle.
// Handshake: start accepted in IDLE/DONE, busy during SHIFT, one-cycle done pulse.
// Optional macro SUB_SERIAL_SIGNED_OVF_EN adds two's-complement overflow capture;
// without it signed_overflow is tied low.
module subtractor_serial_nbit #(
    parameter int unsigned BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] difference,
    output logic                 underflow,
    output logic                 signed_overflow
);

    localparam int unsigned CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [BIT_WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [BIT_WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [BIT_WIDTH-2:0]   diff_sr_q, diff_sr_d;
    logic                   brw_q, brw_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [BIT_WIDTH-1:0]   difference_q, difference_d;
    logic                   underflow_q, underflow_d;

    logic                   bit_d;
    logic                   brw_next;
    logic [BIT_WIDTH-1:0]   diff_shift;

`ifdef SUB_SERIAL_SIGNED_OVF_EN
    logic                   a_sign_q, a_sign_d;
    logic                   b_sign_q, b_sign_d;
    logic                   sovf_q, sovf_d;
`endif

    // Full-subtractor cell and next-state / output computation
    always_comb begin
        bit_d      = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
        brw_next   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
        // diff_sr keeps only the W-1 bits already produced; the current bit
        // completes the word, so the last cycle can load difference directly.
        diff_shift = {bit_d, diff_sr_q};

        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        diff_sr_d    = diff_sr_q;
        brw_d        = brw_q;
        cnt_d        = cnt_q;
        difference_d = difference_q;
        underflow_d  = underflow_q;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
        a_sign_d     = a_sign_q;
        b_sign_d     = b_sign_q;
        sovf_d       = sovf_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SHIFT;
                    a_sr_d   = a;
                    b_sr_d   = b;
                    brw_d    = borrow_in;
                    cnt_d    = '0;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
                    a_sign_d = a[BIT_WIDTH-1];
                    b_sign_d = b[BIT_WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d    = {1'b0, a_sr_q[BIT_WIDTH-1:1]};
                b_sr_d    = {1'b0, b_sr_q[BIT_WIDTH-1:1]};
                diff_sr_d = diff_shift[BIT_WIDTH-1:1];
                brw_d     = brw_next;
                if (cnt_q == CNT_LAST) begin
                    state_d      = DONE;
                    cnt_d        = '0;
                    difference_d = diff_shift;
                    underflow_d  = brw_next;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
                    sovf_d       = (a_sign_q != b_sign_q) &&
                                   (diff_shift[BIT_WIDTH-1] != a_sign_q);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            diff_sr_q    <= '0;
            brw_q        <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            difference_q <= '0;
            underflow_q  <= 1'b0;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
            a_sign_q     <= 1'b0;
            b_sign_q     <= 1'b0;
            sovf_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            diff_sr_q    <= diff_sr_d;
            brw_q        <= brw_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            difference_q <= difference_d;
            underflow_q  <= underflow_d;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
            a_sign_q     <= a_sign_d;
            b_sign_q     <= b_sign_d;
            sovf_q       <= sovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign difference = difference_q;
    assign underflow  = underflow_q;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
    assign signed_overflow = sovf_q;
`else
    assign signed_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_subtractor_serial_nbit.sv
// Bench for subtractor_serial_nbit: narrow (4-bit) and wide (16-bit) instances,
// checked against an arithmetic reference model.
module tb_subtractor_serial_nbit;

    localparam int unsigned W  = 4;
    localparam int unsigned WW = 16;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_rst, start, bin;
    logic [W-1:0]  a, b;
    logic          busy, done, uf, sovf;
    logic [W-1:0]  diff;

    logic          start_w, bin_w;
    logic [WW-1:0] a_w, b_w;
    logic          busy_w, done_w, uf_w, sovf_w;
    logic [WW-1:0] diff_w;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned dir_a [6] = '{9, 3, 0, 15, 8, 7};
    int unsigned dir_b [6] = '{3, 9, 0, 15, 1, 8};
    int unsigned dir_c [6] = '{0, 0, 1, 0,  0, 1};

    subtractor_serial_nbit #(.BIT_WIDTH(W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b), .borrow_in(bin),
        .busy(busy), .done(done), .difference(diff), .underflow(uf),
        .signed_overflow(sovf)
    );

    subtractor_serial_nbit #(.BIT_WIDTH(WW)) dut_w (
        .clk(clk), .n_rst(n_rst), .start(start_w), .a(a_w), .b(b_w), .borrow_in(bin_w),
        .busy(busy_w), .done(done_w), .difference(diff_w), .underflow(uf_w),
        .signed_overflow(sovf_w)
    );

    // Reference model: plain integer arithmetic
    function automatic longint m_diff(int unsigned w, longint av, longint bv, longint cv);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = (av - bv - cv) % m;
        if (r < 0) r = r + m;
        return r;
    endfunction

    function automatic bit m_uf(longint av, longint bv, longint cv);
        return av < (bv + cv);
    endfunction

    function automatic bit m_sovf(int unsigned w, longint av, longint bv, longint cv);
        longint half;
        longint sa;
        longint sb;
        longint r;
        half = longint'(1) << (w - 1);
        sa = (av >= half) ? av - 2 * half : av;
        sb = (bv >= half) ? bv - 2 * half : bv;
        r  = sa - sb - cv;
        return OVF_EN && ((r < -half) || (r > half - 1));
    endfunction

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start_w = 1'b0; a_w = '0; b_w = '0; bin_w = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (diff !== '0) begin n_err++; $display("FAIL reset_diff: got %h want 0", diff); end
        n_vec++; if (uf !== 1'b0 || sovf !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got uf=%b sovf=%b want 0 0", uf, sovf);
        end
        n_vec++; if ({busy_w, done_w, diff_w, uf_w, sovf_w} !== '0) begin
            n_err++; $display("FAIL reset_wide: got busy=%b done=%b diff=%h uf=%b sovf=%b want all 0",
                              busy_w, done_w, diff_w, uf_w, sovf_w);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ed;
            logic eu, es;
            ed = W'(m_diff(W, dir_a[i], dir_b[i], dir_c[i]));
            eu = m_uf(dir_a[i], dir_b[i], dir_c[i]);
            es = m_sovf(W, dir_a[i], dir_b[i], dir_c[i]);
            a = W'(dir_a[i]); b = W'(dir_b[i]); bin = dir_c[i][0]; start = 1'b1;
            @(negedge clk);
            start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            for (int c = 1; c <= int'(W); c++) begin
                n_vec++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL dir%0d_busy c%0d: got busy=%b done=%b want busy=1 done=0", i, c, busy, done);
                end
                @(negedge clk);
            end
            n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_done: got done=%b busy=%b want done=1 busy=0", i, done, busy);
            end
            n_vec++; if (diff !== ed) begin
                n_err++; $display("FAIL dir%0d_diff: got %h want %h", i, diff, ed);
            end
            n_vec++; if (uf !== eu) begin
                n_err++; $display("FAIL dir%0d_underflow: got %b want %b", i, uf, eu);
            end
            n_vec++; if (sovf !== es) begin
                n_err++; $display("FAIL dir%0d_sovf: got %b want %b", i, sovf, es);
            end
            @(negedge clk);
            n_vec++; if (done !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_pulse: got done=%b want 0", i, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned seen;
        a = 4'd12; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 1) @(negedge clk);
        n_vec++; if (diff !== 4'd11) begin n_err++; $display("FAIL pre_reset_diff: got %h want b", diff); end
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;   // cycle 0
        @(negedge clk); start = 1'b0;                   // cycle 1
        @(negedge clk); n_rst = 1'b0;                   // cycle 2
        @(negedge clk); n_rst = 1'b1;                   // cycle 3
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0 0", busy, done);
        end
        n_vec++; if (diff !== '0 || uf !== 1'b0) begin
            n_err++; $display("FAIL midreset_data: got diff=%h uf=%b want 0 0", diff, uf);
        end
        seen = 0;
        repeat (3 * W) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL midreset_nodone: got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;     // cycle 0
        for (int c = 1; c <= int'(W); c++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'b1;
            n_vec++; if (busy !== 1'b1) begin
                n_err++; $display("FAIL b2b_busy c%0d: got %b want 1", c, busy);
            end
        end
        @(negedge clk);                                   // cycle W+1
        n_vec++; if (done !== 1'b1 || diff !== 4'd6 || uf !== 1'b0) begin
            n_err++; $display("FAIL b2b_first: got done=%b diff=%h uf=%b want 1 6 0", done, diff, uf);
        end
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        for (int c = 0; c < int'(W); c++) begin
            n_vec++; if (busy !== 1'b1 || done !== 1'b0 || diff !== 4'd6) begin
                n_err++; $display("FAIL b2b_hold c%0d: got busy=%b done=%b diff=%h want 1 0 6", c, busy, done, diff);
            end
            @(negedge clk);
        end
        n_vec++; if (done !== 1'b1 || diff !== 4'd5 || uf !== 1'b0) begin
            n_err++; $display("FAIL b2b_second: got done=%b diff=%h uf=%b want 1 5 0", done, diff, uf);
        end
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int unsigned ra, rb, rc, tbad;
            bit hold;
            ra = $urandom_range(0, (1 << W) - 1);
            rb = $urandom_range(0, (1 << W) - 1);
            rc = $urandom_range(0, 1);
            hold = 1'($urandom);
            @(negedge clk);
            a = W'(ra); b = W'(rb); bin = rc[0]; start = 1'b1;
            tbad = 0;
            for (int c = 1; c <= int'(W); c++) begin
                @(negedge clk);
                start = hold ? 1'($urandom) : 1'b0;
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
                if (busy !== 1'b1 || done !== 1'b0) tbad++;
            end
            @(negedge clk);
            start = 1'b0;
            n_vec++; if (tbad != 0 || done !== 1'b1) begin
                n_err++; $display("FAIL rnd%0d_timing: got %0d bad busy cycles, done=%b want 0 1", i, tbad, done);
            end
            n_vec++; if (diff !== W'(m_diff(W, ra, rb, rc))) begin
                n_err++; $display("FAIL rnd%0d_diff a=%0d b=%0d c=%0d: got %h want %h", i, ra, rb, rc,
                                  diff, W'(m_diff(W, ra, rb, rc)));
            end
            n_vec++; if (uf !== m_uf(ra, rb, rc) || sovf !== m_sovf(W, ra, rb, rc)) begin
                n_err++; $display("FAIL rnd%0d_flags a=%0d b=%0d c=%0d: got uf=%b sovf=%b want %b %b", i, ra, rb, rc,
                                  uf, sovf, m_uf(ra, rb, rc), m_sovf(W, ra, rb, rc));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wide();
        for (int i = 0; i < 4; i++) begin
            int unsigned ra, rb, rc, tbad;
            if (i == 0) begin ra = 32'h8000; rb = 1; rc = 0; end
            else begin
                ra = $urandom_range(0, 16'hFFFF); rb = $urandom_range(0, 16'hFFFF); rc = $urandom_range(0, 1);
            end
            @(negedge clk);
            a_w = WW'(ra); b_w = WW'(rb); bin_w = rc[0]; start_w = 1'b1;
            tbad = 0;
            for (int c = 1; c <= int'(WW); c++) begin
                @(negedge clk);
                start_w = 1'b0; a_w = WW'($urandom);
                if (busy_w !== 1'b1 || done_w !== 1'b0) tbad++;
            end
            @(negedge clk);                               // cycle 17
            n_vec++; if (tbad != 0 || done_w !== 1'b1) begin
                n_err++; $display("FAIL wide%0d_timing: got %0d bad busy cycles, done=%b want 0 1", i, tbad, done_w);
            end
            n_vec++; if (diff_w !== WW'(m_diff(WW, ra, rb, rc)) || uf_w !== m_uf(ra, rb, rc)
                         || sovf_w !== m_sovf(WW, ra, rb, rc)) begin
                n_err++; $display("FAIL wide%0d_result: got diff=%h uf=%b sovf=%b want %h %b %b", i, diff_w, uf_w, sovf_w,
                                  WW'(m_diff(WW, ra, rb, rc)), m_uf(ra, rb, rc), m_sovf(WW, ra, rb, rc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
